// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the multicycle RV32I/M core: state register, datapath enables,
// memory-ready waits, multi-cycle M-op execute and retire counting.
// Build macro MEM_TIMEOUT_EN adds a bounded memory wait with a sticky timeout flag.
//
// state | meaning
// IF    | fetch, wait on imem_ready
// ID    | decode
// EX1   | execute / branch resolve / M-op start
// EX2   | taken-branch PC update
// MEM   | data access, wait on dmem_ready
// WB    | register writeback and retire
// EXM   | extra M-extension execute cycles
// HALT  | terminal until reset
module multicycle_ctrl_fsm #(
   parameter int MUL_LATENCY = 4,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic [6:0]       funct7,
   input  logic             bcond,
   input  logic             halt_req,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic [3:0]       state,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic             retire,
   output logic [CNT_W-1:0] retire_count,
   output logic             halted,
   output logic             mem_timeout
);

   typedef enum logic [3:0] {
      S_IF   = 4'd0,
      S_ID   = 4'd1,
      S_EX1  = 4'd2,
      S_EX2  = 4'd3,
      S_MEM  = 4'd4,
      S_WB   = 4'd5,
      S_EXM  = 4'd6,
      S_HALT = 4'd7
   } state_t;

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;
   localparam logic [6:0] F7_MULDIV    = 7'b0000001;

   localparam int              MUL_W     = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [MUL_W-1:0] MUL_LOAD = MUL_W'(MUL_LATENCY - 1);
   localparam bit              MUL_MULTI = (MUL_LATENCY > 1);

   if (MUL_LATENCY < 1 || MEM_TIMEOUT < 1) begin : g_param_check
      $error("multicycle_ctrl_fsm: MUL_LATENCY and MEM_TIMEOUT must be >= 1");
   end

   state_t           state_q, state_next;
   logic [MUL_W-1:0] mul_cnt, mul_next;

`ifdef MEM_TIMEOUT_EN
   localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting, timeout_hit;
`endif

   assign state = state_q;

   always_comb begin
      state_next = state_q;
      mul_next   = mul_cnt;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
`ifdef MEM_TIMEOUT_EN
      waiting     = 1'b0;
      timeout_hit = 1'b0;
`endif
      case (state_q)
         S_IF: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               if (opcode == OP_ECALL) begin
                  if (halt_req) begin
                     state_next = S_HALT;
                  end else begin
                     state_next = S_IF;
                     pc_write   = 1'b1;
                     retire     = 1'b1;
                  end
               end else if (opcode == OP_JAL) begin
                  state_next = S_EX1;
               end else begin
                  state_next = S_ID;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (wait_cnt == WAIT_LAST) begin
               state_next  = S_HALT;
               timeout_hit = 1'b1;
            end else begin
               waiting = 1'b1;
            end
`endif
         end
         S_ID: state_next = S_EX1;
         S_EX1: begin
            case (opcode)
               OP_BRANCH: begin
                  if (bcond) begin
                     state_next = S_EX2;
                  end else begin
                     state_next = S_IF;
                     pc_write   = 1'b1;
                     retire     = 1'b1;
                  end
               end
               OP_ARITH: begin
                  if (funct7 == F7_MULDIV && MUL_MULTI) begin
                     state_next = S_EXM;
                     mul_next   = MUL_LOAD;
                  end else begin
                     state_next = S_WB;
                  end
               end
               OP_ARITH_IMM, OP_JAL, OP_JALR: state_next = S_WB;
               OP_LOAD, OP_STORE:             state_next = S_MEM;
               default: begin
                  // unknown opcode: skip it without counting a retire
                  state_next = S_IF;
                  pc_write   = 1'b1;
               end
            endcase
         end
         S_EXM: begin
            mul_next = mul_cnt - MUL_W'(1);
            if (mul_cnt == MUL_W'(1)) state_next = S_WB;
         end
         S_EX2: begin
            state_next = S_IF;
            pc_write   = 1'b1;
            retire     = 1'b1;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               if (opcode == OP_LOAD) begin
                  state_next = S_WB;
               end else begin
                  state_next = S_IF;
                  pc_write   = 1'b1;
                  retire     = 1'b1;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (wait_cnt == WAIT_LAST) begin
               state_next  = S_HALT;
               timeout_hit = 1'b1;
            end else begin
               waiting = 1'b1;
            end
`endif
         end
         S_WB: begin
            state_next = S_IF;
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            retire     = 1'b1;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IF;
         mul_cnt      <= '0;
         retire_count <= '0;
         halted       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         mem_timeout  <= 1'b0;
         wait_cnt     <= '0;
`endif
      end else begin
         state_q <= state_next;
         mul_cnt <= mul_next;
         if (retire) retire_count <= retire_count + CNT_W'(1);
         if (state_next == S_HALT) halted <= 1'b1;
`ifdef MEM_TIMEOUT_EN
         if (timeout_hit) mem_timeout <= 1'b1;
         // any non-waiting cycle restarts the count, covering entry to IF/MEM
         wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
`endif
      end
   end

`ifndef MEM_TIMEOUT_EN
   assign mem_timeout = 1'b0;
`endif

endmodule
